// File: rtl/utils_pkg.sv
// Shared definitions for the machine timer: register offsets, FSM states,
// request bundle and a byte-strobe merge helper.
package utils_pkg;

  localparam logic [31:0] MTIMER_MSIP    = 32'h0000_0000;
  localparam logic [31:0] MTIMER_CMP_LO  = 32'h0000_0008;
  localparam logic [31:0] MTIMER_CMP_HI  = 32'h0000_000C;
  localparam logic [31:0] MTIMER_TIME_LO = 32'h0000_0010;
  localparam logic [31:0] MTIMER_TIME_HI = 32'h0000_0014;

  typedef enum logic {
    MT_IDLE,
    MT_RESP
  } mtimer_st_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } s_mtimer_req_t;

  // Replace only the bytes of old_val whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Free-running divider: pulses tick_o once every PRESCALER clocks.
// Kept standalone so a later watchdog can reuse it.
module mtimer_prescaler #(
  parameter int unsigned PRESCALER = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] LAST = CW'(PRESCALER - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick_o = (count_q == LAST);

  // Count 0..PRESCALER-1, wrapping to zero on the tick cycle.
  always_comb begin
    count_d = count_q + CW'(1);
    if (count_q == LAST) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mtimer_irq_gen.sv
// Memory-mapped machine timer (mtime/mtimecmp) and software interrupt (msip)
// behind a single-outstanding valid/ready slave port.
module mtimer_irq_gen
  import utils_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PRESCALER    = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  timer_irq_o,
  output logic                  sw_irq_o,
  output logic [63:0]           mtime_o
);

  mtimer_st_t    state_q, state_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          timer_irq_q, timer_irq_d;
  logic          sw_irq_q, sw_irq_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  s_mtimer_req_t req;
  logic          tick;
  logic          accept;
  logic          hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
  logic          addr_ok;
  logic [31:0]   rd_val;

  assign req = '{we: req_we_i, addr: 32'(req_addr_i), wdata: req_wdata_i, wstrb: req_wstrb_i};

  assign accept      = req_valid_i && (state_q == MT_IDLE);
  assign req_ready_o = (state_q == MT_IDLE);
  assign rsp_valid_o = (state_q == MT_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign timer_irq_o = timer_irq_q;
  assign sw_irq_o    = sw_irq_q;
  assign mtime_o     = mtime_q;

  mtimer_prescaler #(
    .PRESCALER(PRESCALER)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  // Decode the request address and select read data from pre-write state.
  always_comb begin
    hit_msip    = (req.addr == MTIMER_MSIP);
    hit_cmp_lo  = (req.addr == MTIMER_CMP_LO);
    hit_cmp_hi  = (req.addr == MTIMER_CMP_HI);
    hit_time_lo = (req.addr == MTIMER_TIME_LO);
    hit_time_hi = (req.addr == MTIMER_TIME_HI);
    addr_ok     = (req.addr[1:0] == 2'b00) &&
                  (hit_msip || hit_cmp_lo || hit_cmp_hi || hit_time_lo || hit_time_hi);
    rd_val      = '0;
    if (hit_msip) begin
      rd_val = {31'b0, msip_q};
    end else if (hit_cmp_lo) begin
      rd_val = mtimecmp_q[31:0];
    end else if (hit_cmp_hi) begin
      rd_val = mtimecmp_q[63:32];
    end else if (hit_time_lo) begin
      rd_val = mtime_q[31:0];
    end else if (hit_time_hi) begin
      rd_val = mtime_q[63:32];
    end
  end

  // Transaction FSM plus register updates; a bus write to an mtime half
  // overrides the tick increment for that cycle.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtime_d     = tick ? (mtime_q + 64'd1) : mtime_q;
    timer_irq_d = (mtime_q >= mtimecmp_q);
    sw_irq_d    = msip_q;

    case (state_q)
      MT_IDLE: begin
        if (accept) begin
          state_d     = MT_RESP;
          rsp_err_d   = !addr_ok;
          rsp_rdata_d = (!req.we && addr_ok) ? rd_val : 32'd0;
          if (req.we && addr_ok) begin
            if (hit_msip && req.wstrb[0]) begin
              msip_d = req.wdata[0];
            end
            if (hit_cmp_lo) begin
              mtimecmp_d[31:0] = apply_wstrb(mtimecmp_q[31:0], req.wdata, req.wstrb);
            end
            if (hit_cmp_hi) begin
              mtimecmp_d[63:32] = apply_wstrb(mtimecmp_q[63:32], req.wdata, req.wstrb);
            end
            if (hit_time_lo) begin
              mtime_d = {mtime_q[63:32], apply_wstrb(mtime_q[31:0], req.wdata, req.wstrb)};
            end
            if (hit_time_hi) begin
              mtime_d = {apply_wstrb(mtime_q[63:32], req.wdata, req.wstrb), mtime_q[31:0]};
            end
          end
        end
      end
      MT_RESP: begin
        if (rsp_ready_i) begin
          state_d     = MT_IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = MT_IDLE;
      end
    endcase
  end

  // State and register file; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MT_IDLE;
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RST;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      sw_irq_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      sw_irq_q    <= sw_irq_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mtimer_irq_gen.sv
// Bench for mtimer_irq_gen: two instances (PRESCALER 1 and 4) share one
// request stream and are compared against a behavioural timer model.
module tb_mtimer_irq_gen;

  localparam int unsigned P0 = 1;
  localparam int unsigned P1 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [7:0]  req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_wstrb_i = '0;
  logic        rsp_ready_i = 1'b1;

  logic        req_ready_0, rsp_valid_0, rsp_err_0, timer_irq_0, sw_irq_0;
  logic [31:0] rsp_rdata_0;
  logic [63:0] mtime_0;
  logic        req_ready_1, rsp_valid_1, rsp_err_1, timer_irq_1, sw_irq_1;
  logic [31:0] rsp_rdata_1;
  logic [63:0] mtime_1;

  int checks = 0;
  int failures = 0;

  mtimer_irq_gen #(.ADDR_WIDTH(8), .PRESCALER(P0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_0), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_0), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_0),
    .rsp_err_o(rsp_err_0), .timer_irq_o(timer_irq_0), .sw_irq_o(sw_irq_0), .mtime_o(mtime_0)
  );

  mtimer_irq_gen #(.ADDR_WIDTH(8), .PRESCALER(P1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_1), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_1), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_1),
    .rsp_err_o(rsp_err_1), .timer_irq_o(timer_irq_1), .sw_irq_o(sw_irq_1), .mtime_o(mtime_1)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  longint unsigned m_edge;
  logic [63:0] m_time [2];
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_tirq [2];
  logic        m_sw;
  logic [31:0] exp_rd [2];
  logic        exp_err;
  int          pend_seq = 0;
  int          seen_seq;
  logic [63:0] mdl_nt;
  logic        mdl_take, mdl_map, mdl_tick;

  function automatic int unsigned period(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    return (a == 8'h00) || (a == 8'h08) || (a == 8'h0C) || (a == 8'h10) || (a == 8'h14);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [63:0] t, input logic [7:0] a);
    case (a)
      8'h00:   return {31'b0, m_msip};
      8'h08:   return m_cmp[31:0];
      8'h0C:   return m_cmp[63:32];
      8'h10:   return t[31:0];
      8'h14:   return t[63:32];
      default: return 32'd0;
    endcase
  endfunction

  // mtime advances once every period(i) clocks since reset; an accepted
  // write replaces bytes and suppresses that clock's increment for mtime.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge   <= 0;
      m_time[0] <= '0;
      m_time[1] <= '0;
      m_cmp    <= '1;
      m_msip   <= 1'b0;
      m_tirq[0] <= 1'b0;
      m_tirq[1] <= 1'b0;
      m_sw     <= 1'b0;
      exp_rd[0] <= '0;
      exp_rd[1] <= '0;
      exp_err  <= 1'b0;
      seen_seq <= pend_seq;
    end else begin
      mdl_take = (pend_seq != seen_seq);
      mdl_map  = is_mapped(req_addr_i);
      m_edge <= m_edge + 1;
      m_sw   <= m_msip;
      for (int i = 0; i < 2; i++) begin
        m_tirq[i] <= (m_time[i] >= m_cmp);
        mdl_tick = (((m_edge + 1) % period(i)) == 0);
        mdl_nt = mdl_tick ? m_time[i] + 64'd1 : m_time[i];
        if (mdl_take && req_we_i && req_addr_i == 8'h10)
          mdl_nt = {m_time[i][63:32], merge(m_time[i][31:0], req_wdata_i, req_wstrb_i)};
        if (mdl_take && req_we_i && req_addr_i == 8'h14)
          mdl_nt = {merge(m_time[i][63:32], req_wdata_i, req_wstrb_i), m_time[i][31:0]};
        m_time[i] <= mdl_nt;
        if (mdl_take)
          exp_rd[i] <= (!req_we_i && mdl_map) ? model_read(m_time[i], req_addr_i) : 32'd0;
      end
      if (mdl_take) begin
        seen_seq <= pend_seq;
        exp_err  <= !mdl_map;
        if (req_we_i && req_addr_i == 8'h00 && req_wstrb_i[0]) m_msip <= req_wdata_i[0];
        if (req_we_i && req_addr_i == 8'h08)
          m_cmp <= {m_cmp[63:32], merge(m_cmp[31:0], req_wdata_i, req_wstrb_i)};
        if (req_we_i && req_addr_i == 8'h0C)
          m_cmp <= {merge(m_cmp[63:32], req_wdata_i, req_wstrb_i), m_cmp[31:0]};
      end
    end
  end

  // ---------------- bus driver ----------------
  logic [31:0] last_rd0, last_rd1;
  logic        last_err0, last_err1, last_tirq0, last_sw0;
  logic [63:0] last_mtime0;

  task automatic bus_txn(input logic we, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
    int n;
    @(negedge clk);
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_wstrb_i = ws;
    pend_seq++;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(rsp_valid_0 && rsp_valid_1) && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(rsp_valid_0 && rsp_valid_1)) begin
      failures++;
      $display("[TB] FAIL rsp_timeout addr=%h valid0=%b valid1=%b required=1", addr, rsp_valid_0, rsp_valid_1);
    end
    last_rd0    = rsp_rdata_0;
    last_rd1    = rsp_rdata_1;
    last_err0   = rsp_err_0;
    last_err1   = rsp_err_1;
    last_tirq0  = timer_irq_0;
    last_sw0    = sw_irq_0;
    last_mtime0 = mtime_0;
    @(posedge clk);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({timer_irq_0, sw_irq_0, rsp_valid_0, rsp_err_0, req_ready_0, req_ready_1} !== 6'b000011) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=000011",
               {timer_irq_0, sw_irq_0, rsp_valid_0, rsp_err_0, req_ready_0, req_ready_1});
    end
    checks++;
    if (mtime_0 !== 64'd0 || mtime_1 !== 64'd0 || rsp_rdata_0 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mtime got=%h/%h rdata=%h exp=0", mtime_0, mtime_1, rsp_rdata_0);
    end
    rst = 1'b0;
    bus_txn(1'b0, 8'h08, 32'd0, 4'h0);
    checks++;
    if (last_rd0 !== 32'hFFFF_FFFF || last_rd1 !== 32'hFFFF_FFFF || last_err0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cmp_lo got=%h err=%b exp=ffffffff", last_rd0, last_err0);
    end
    bus_txn(1'b0, 8'h0C, 32'd0, 4'h0);
    checks++;
    if (last_rd0 !== 32'hFFFF_FFFF || last_rd1 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL reset_cmp_hi got=%h exp=ffffffff", last_rd0);
    end
  endtask

  task automatic test_msip();
    bus_txn(1'b1, 8'h00, 32'h1, 4'hF);
    checks++;
    if (last_sw0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sw_irq_early got=%b exp=0", last_sw0);
    end
    @(negedge clk);
    checks++;
    if (sw_irq_0 !== 1'b1 || sw_irq_1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sw_irq_set got=%b%b exp=11", sw_irq_0, sw_irq_1);
    end
    bus_txn(1'b1, 8'h00, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (sw_irq_0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sw_irq_clr got=%b exp=0", sw_irq_0);
    end
    bus_txn(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF);
    bus_txn(1'b0, 8'h00, 32'd0, 4'h0);
    checks++;
    if (last_rd0 !== 32'h1 || last_rd1 !== 32'h1) begin
      failures++;
      $display("[TB] FAIL msip_read got=%h exp=00000001", last_rd0);
    end
  endtask

  task automatic test_timer();
    int c20;
    int ci;
    bus_txn(1'b1, 8'h14, 32'd0, 4'hF);
    bus_txn(1'b1, 8'h10, 32'd0, 4'hF);
    bus_txn(1'b1, 8'h0C, 32'd0, 4'hF);
    bus_txn(1'b1, 8'h08, 32'd20, 4'hF);
    c20 = -1;
    ci  = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (timer_irq_0 !== m_tirq[0] || timer_irq_1 !== m_tirq[1] ||
          mtime_0 !== m_time[0] || mtime_1 !== m_time[1]) begin
        failures++;
        $display("[TB] FAIL timer_track c=%0d irq=%b%b mtime0=%0d exp irq=%b%b mtime0=%0d",
                 c, timer_irq_0, timer_irq_1, mtime_0, m_tirq[0], m_tirq[1], m_time[0]);
      end
      if (mtime_0 == 64'd20 && c20 < 0) c20 = c;
      if (timer_irq_0 && ci < 0) ci = c;
    end
    checks++;
    if (c20 < 0 || ci != c20 + 1) begin
      failures++;
      $display("[TB] FAIL timer_rise_cycle got=%0d exp=%0d", ci, c20 + 1);
    end
    bus_txn(1'b1, 8'h08, 32'd1000, 4'hF);
    checks++;
    if (last_tirq0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timer_fall_early got=%b exp=1", last_tirq0);
    end
    @(negedge clk);
    checks++;
    if (timer_irq_0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timer_fall got=%b exp=0", timer_irq_0);
    end
  endtask

  task automatic test_prescaler();
    logic [63:0] s0, s1;
    logic [63:0] prev1;
    bit          wrapped;
    @(negedge clk);
    s0 = mtime_0;
    s1 = mtime_1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (mtime_0 !== m_time[0] || mtime_1 !== m_time[1]) begin
        failures++;
        $display("[TB] FAIL presc_track got=%0d/%0d exp=%0d/%0d", mtime_0, mtime_1, m_time[0], m_time[1]);
      end
    end
    checks++;
    if (mtime_0 - s0 !== 64'd12 || mtime_1 - s1 !== 64'd3) begin
      failures++;
      $display("[TB] FAIL presc_rate got=%0d/%0d exp=12/3", mtime_0 - s0, mtime_1 - s1);
    end
    bus_txn(1'b1, 8'h14, 32'hFFFF_FFFF, 4'hF);
    bus_txn(1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (last_mtime0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL wrap_pre got=%h exp=ffffffffffffffff", last_mtime0);
    end
    @(negedge clk);
    checks++;
    if (mtime_0 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL wrap_p1 got=%h exp=0", mtime_0);
    end
    wrapped = 1'b0;
    prev1 = mtime_1;
    for (int c = 0; c < 8 && !wrapped; c++) begin
      checks++;
      if (mtime_1 !== m_time[1]) begin
        failures++;
        $display("[TB] FAIL wrap_track got=%h exp=%h", mtime_1, m_time[1]);
      end
      if (mtime_1 == 64'd0) wrapped = 1'b1;
      else prev1 = mtime_1;
      if (!wrapped) @(negedge clk);
    end
    checks++;
    if (!wrapped || prev1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL wrap_p4 wrapped=%b prev=%h exp=1/ffffffffffffffff", wrapped, prev1);
    end
  endtask

  task automatic test_errors();
    bus_txn(1'b0, 8'h04, 32'd0, 4'h0);
    checks++;
    if (last_err0 !== 1'b1 || last_err1 !== 1'b1 || last_rd0 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL err_read04 err=%b%b rd=%h exp err=11 rd=0", last_err0, last_err1, last_rd0);
    end
    bus_txn(1'b1, 8'h09, 32'h1234_5678, 4'hF);
    checks++;
    if (last_err0 !== 1'b1 || last_rd0 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL err_write09 err=%b rd=%h exp err=1 rd=0", last_err0, last_rd0);
    end
    bus_txn(1'b1, 8'h18, 32'h0, 4'hF);
    bus_txn(1'b0, 8'h08, 32'd0, 4'h0);
    checks++;
    if (last_rd0 !== 32'd1000 || last_err0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_nochange_cmp got=%h exp=000003e8", last_rd0);
    end
    bus_txn(1'b1, 8'h00, 32'h0, 4'h0);
    bus_txn(1'b0, 8'h00, 32'd0, 4'h0);
    checks++;
    if (last_rd0 !== 32'h1 || last_err0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wstrb0_noeffect got=%h err=%b exp=00000001", last_rd0, last_err0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    int n;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 8'h08;
    pend_seq++;
    @(posedge clk);
    #1;
    req_addr_i = 8'h00;
    @(negedge clk);
    first = rsp_rdata_0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid_0 !== 1'b1 || req_ready_0 !== 1'b0 || rsp_rdata_0 !== first ||
          rsp_rdata_0 !== 32'd1000 || rsp_rdata_0 !== exp_rd[0]) begin
        failures++;
        $display("[TB] FAIL hold c=%0d valid=%b ready=%b rd=%h exp valid=1 ready=0 rd=000003e8",
                 c, rsp_valid_0, req_ready_0, rsp_rdata_0);
      end
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid_0 !== 1'b0 || req_ready_0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_release valid=%b ready=%b exp valid=0 ready=1", rsp_valid_0, req_ready_0);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid_0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_rdata_0 !== {31'b0, m_msip}) begin
      failures++;
      $display("[TB] FAIL queued_read valid=%b rd=%h exp valid=1 rd=%h", rsp_valid_0, rsp_rdata_0, {31'b0, m_msip});
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        we;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0: a = 8'h00;
        1: a = 8'h04;
        2: a = 8'h08;
        3: a = 8'h0C;
        4: a = 8'h10;
        5: a = 8'h14;
        6: a = 8'h18;
        default: a = 8'($urandom);
      endcase
      we = 1'($urandom);
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      bus_txn(we, a, wd, ws);
      checks++;
      if (last_rd0 !== exp_rd[0] || last_rd1 !== exp_rd[1] ||
          last_err0 !== exp_err || last_err1 !== exp_err) begin
        failures++;
        $display("[TB] FAIL rand_rsp t=%0d a=%h we=%b rd=%h/%h err=%b%b exp rd=%h/%h err=%b",
                 t, a, we, last_rd0, last_rd1, last_err0, last_err1, exp_rd[0], exp_rd[1], exp_err);
      end
      @(negedge clk);
      checks++;
      if (mtime_0 !== m_time[0] || mtime_1 !== m_time[1] || timer_irq_0 !== m_tirq[0] ||
          timer_irq_1 !== m_tirq[1] || sw_irq_0 !== m_sw || sw_irq_1 !== m_sw) begin
        failures++;
        $display("[TB] FAIL rand_state t=%0d mtime=%h/%h irq=%b%b sw=%b%b exp mtime=%h/%h irq=%b%b sw=%b",
                 t, mtime_0, mtime_1, timer_irq_0, timer_irq_1, sw_irq_0, sw_irq_1,
                 m_time[0], m_time[1], m_tirq[0], m_tirq[1], m_sw);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 8'h08;
    req_wdata_i = 32'h55;
    req_wstrb_i = 4'hF;
    pend_seq++;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid_0 !== 1'b0 || req_ready_0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid valid=%b ready=%b exp valid=0 ready=1", rsp_valid_0, req_ready_0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_txn(1'b0, 8'h08, 32'd0, 4'h0);
    checks++;
    if (last_rd0 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL reset_mid_cmp got=%h exp=ffffffff", last_rd0);
    end
  endtask

  initial begin
    test_reset();
    test_msip();
    test_timer();
    test_prescaler();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
